// File: rtl/imm_sched.sv
// Two-slot immediate scheduler: arbitrates decode slots onto one shared
// immediate generator with a one-entry registered output stage. IMMSCHED_RR_EN selects round-robin arbitration.

`ifndef INST_LEN
`define INST_LEN 32
`endif
`ifndef REG_LEN
`define REG_LEN 32
`endif

module imm_gen (
  input  logic [`INST_LEN-1:0] inst,
  output logic [`REG_LEN-1:0]  imm,
  output logic [2:0]           fmt
);
  typedef enum logic [2:0] {
    FMT_NONE = 3'd0,
    FMT_I    = 3'd1,
    FMT_S    = 3'd2,
    FMT_B    = 3'd3,
    FMT_U    = 3'd4,
    FMT_J    = 3'd5
  } fmt_e;

  fmt_e        f;
  logic [31:0] imm32;

  always_comb begin
    f = FMT_NONE;
    case (inst[6:0])
      7'b0110111, 7'b0010111:            f = FMT_U;
      7'b1101111:                        f = FMT_J;
      7'b1100111, 7'b0000011, 7'b0010011: f = FMT_I;
      7'b0100011:                        f = FMT_S;
      7'b1100011:                        f = FMT_B;
      default:                           f = FMT_NONE;
    endcase
  end

  always_comb begin
    imm32 = '0;
    case (f)
      FMT_I: imm32 = {{20{inst[31]}}, inst[31:20]};
      FMT_S: imm32 = {{20{inst[31]}}, inst[31:25], inst[11:7]};
      FMT_B: imm32 = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
      FMT_U: imm32 = {inst[31:12], 12'b0};
      FMT_J: imm32 = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
      default: imm32 = '0;
    endcase
  end

  // Wider register files get the 32-bit value sign-extended.
  assign imm = `REG_LEN'($signed(imm32));
  assign fmt = f;
endmodule

module imm_sched #(
  parameter int TAG_W = 6
) (
  input  logic                 clk,
  input  logic                 reset_x,
  input  logic                 in0_valid,
  input  logic [`INST_LEN-1:0] in0_inst,
  input  logic [TAG_W-1:0]     in0_tag,
  output logic                 in0_ready,
  input  logic                 in1_valid,
  input  logic [`INST_LEN-1:0] in1_inst,
  input  logic [TAG_W-1:0]     in1_tag,
  output logic                 in1_ready,
  input  logic                 flush,
  output logic                 out_valid,
  output logic [`REG_LEN-1:0]  out_imm,
  output logic [2:0]           out_fmt,
  output logic [TAG_W-1:0]     out_tag,
  output logic                 out_src,
  input  logic                 out_ready
);
  localparam int NUM_SLOTS = 2;

  typedef struct packed {
    logic [`REG_LEN-1:0] imm;
    logic [2:0]          fmt;
    logic [TAG_W-1:0]    tag;
    logic                src;
  } rsp_t;

  logic [NUM_SLOTS-1:0]                req_vld;
  logic [NUM_SLOTS-1:0][`INST_LEN-1:0] req_inst;
  logic [NUM_SLOTS-1:0][TAG_W-1:0]     req_tag;
  logic [NUM_SLOTS-1:0]                rdy;

  logic gnt, free, take, acc, vld_q;
  rsp_t rsp_d, rsp_q;

  assign req_vld  = {in1_valid, in0_valid};
  assign req_inst = {in1_inst, in0_inst};
  assign req_tag  = {in1_tag, in0_tag};

`ifdef IMMSCHED_RR_EN
  logic prio;

  always_ff @(posedge clk or negedge reset_x) begin
    if (!reset_x)              prio <= 1'b0;
    else if (acc)              prio <= ~gnt;
  end

  always_comb begin
    gnt = req_vld[1];
    if (&req_vld) gnt = prio;
  end
`else
  // Slot 1 only ever wins when slot 0 is idle.
  always_comb begin
    gnt = !req_vld[0] && req_vld[1];
  end
`endif

  assign free = !vld_q || out_ready;
  assign take = free && !flush;
  assign rdy  = take ? (gnt ? 2'b10 : 2'b01) : 2'b00;
  assign acc  = |(rdy & req_vld);

  assign in0_ready = rdy[0];
  assign in1_ready = rdy[1];

  imm_gen u_gen (
    .inst (req_inst[gnt]),
    .imm  (rsp_d.imm),
    .fmt  (rsp_d.fmt)
  );

  assign rsp_d.tag = req_tag[gnt];
  assign rsp_d.src = gnt;

  // Flush outranks accept and drain; payload holds across a plain drain.
  always_ff @(posedge clk or negedge reset_x) begin
    if (!reset_x) begin
      vld_q <= 1'b0;
      rsp_q <= '0;
    end else if (flush) begin
      vld_q <= 1'b0;
    end else if (acc) begin
      vld_q <= 1'b1;
      rsp_q <= rsp_d;
    end else if (out_ready) begin
      vld_q <= 1'b0;
    end
  end

  assign out_valid = vld_q;
  assign out_imm   = rsp_q.imm;
  assign out_fmt   = rsp_q.fmt;
  assign out_tag   = rsp_q.tag;
  assign out_src   = rsp_q.src;
endmodule

// File: tb/tb_imm_sched.sv
// Bench for imm_sched: format table, arbitration, backpressure, flush and
// reset corners, with a queue of expected results scored on every edge.
module tb_imm_sched;
  localparam int TAG_W = 6;
`ifdef IMMSCHED_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  typedef struct {
    logic [31:0]      imm;
    logic [2:0]       fmt;
    logic [TAG_W-1:0] tag;
    logic             src;
  } res_t;

  typedef struct {
    logic             slot;
    logic [31:0]      inst;
    logic [TAG_W-1:0] tag;
    logic [31:0]      imm;
    logic [2:0]       fmt;
  } vec_t;

  logic clk = 1'b0, reset_x = 1'b0;
  logic in0_valid = 0, in1_valid = 0, flush = 0, out_ready = 0;
  logic [31:0] in0_inst = '0, in1_inst = '0;
  logic [TAG_W-1:0] in0_tag = '0, in1_tag = '0;
  logic in0_ready, in1_ready, out_valid, out_src;
  logic [31:0] out_imm;
  logic [2:0] out_fmt;
  logic [TAG_W-1:0] out_tag;

  int   errors = 0, checks = 0;
  res_t exp0, exp1;
  res_t sbq[$];
  vec_t vecs[12];

  always #5 clk = ~clk;

  imm_sched #(.TAG_W(TAG_W)) dut (
    .clk(clk), .reset_x(reset_x),
    .in0_valid(in0_valid), .in0_inst(in0_inst), .in0_tag(in0_tag), .in0_ready(in0_ready),
    .in1_valid(in1_valid), .in1_inst(in1_inst), .in1_tag(in1_tag), .in1_ready(in1_ready),
    .flush(flush),
    .out_valid(out_valid), .out_imm(out_imm), .out_fmt(out_fmt), .out_tag(out_tag),
    .out_src(out_src), .out_ready(out_ready)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic slot, input logic [31:0] inst, input logic [TAG_W-1:0] tag,
                       input logic [31:0] imm, input logic [2:0] fmt);
    res_t r;
    r.imm = imm; r.fmt = fmt; r.tag = tag; r.src = slot;
    if (slot) begin in1_valid = 1; in1_inst = inst; in1_tag = tag; exp1 = r; end
    else      begin in0_valid = 1; in0_inst = inst; in0_tag = tag; exp0 = r; end
  endtask

  // One clock: note what the DUT should take, advance, score the output stage.
  task automatic step();
    logic a0, a1, drn, fl;
    #1;
    chk("ready_onehot", {31'd0, in0_ready && in1_ready}, 32'd0);
    a0 = in0_valid && in0_ready;
    a1 = in1_valid && in1_ready;
    drn = out_valid && out_ready;
    fl = flush;
    @(posedge clk); #1;
    if (fl) sbq.delete();
    else begin
      if (drn && sbq.size() != 0) void'(sbq.pop_front());
      if (a0) sbq.push_back(exp0);
      if (a1) sbq.push_back(exp1);
    end
    chk("out_valid", {31'd0, out_valid}, {31'd0, sbq.size() != 0});
    if (out_valid && sbq.size() != 0) begin
      chk("out_imm", out_imm, sbq[0].imm);
      chk("out_fmt", {29'd0, out_fmt}, {29'd0, sbq[0].fmt});
      chk("out_tag", {26'd0, out_tag}, {26'd0, sbq[0].tag});
      chk("out_src", {31'd0, out_src}, {31'd0, sbq[0].src});
    end
  endtask

  task automatic chk_rdy(input string name, input logic e0, input logic e1);
    #1;
    chk({name, "_in0_ready"}, {31'd0, in0_ready}, {31'd0, e0});
    chk({name, "_in1_ready"}, {31'd0, in1_ready}, {31'd0, e1});
  endtask

  task automatic chk_zero(input string name);
    chk({name, "_valid"}, {31'd0, out_valid}, 32'd0);
    chk({name, "_imm"}, out_imm, 32'd0);
    chk({name, "_fmt"}, {29'd0, out_fmt}, 32'd0);
    chk({name, "_tag"}, {26'd0, out_tag}, 32'd0);
    chk({name, "_src"}, {31'd0, out_src}, 32'd0);
  endtask

  task automatic idle();
    in0_valid = 0; in1_valid = 0; flush = 0;
  endtask

  initial begin
    logic [31:0] s_imm;
    logic [TAG_W-1:0] s_tag;
    logic s_src;
    logic es;

    vecs[0]  = '{1'b1, 32'h12345037, 6'd1,  32'h12345000, 3'd4};
    vecs[1]  = '{1'b1, 32'hFE000EE3, 6'd2,  32'hFFFFFFFC, 3'd3};
    vecs[2]  = '{1'b1, 32'h0040006F, 6'd3,  32'h00000004, 3'd5};
    vecs[3]  = '{1'b1, 32'h00112623, 6'd4,  32'h0000000C, 3'd2};
    vecs[4]  = '{1'b1, 32'h002081B3, 6'd6,  32'h00000000, 3'd0};
    vecs[5]  = '{1'b0, 32'h800000B7, 6'd7,  32'h80000000, 3'd4};
    vecs[6]  = '{1'b0, 32'h80002083, 6'd8,  32'hFFFFF800, 3'd1};
    vecs[7]  = '{1'b1, 32'h000080E7, 6'd9,  32'h00000000, 3'd1};
    vecs[8]  = '{1'b0, 32'hFFFFF017, 6'd10, 32'hFFFFF000, 3'd4};
    vecs[9]  = '{1'b1, 32'hFFDFF06F, 6'd11, 32'hFFFFFFFC, 3'd5};
    vecs[10] = '{1'b0, 32'hFFFFFFFF, 6'd12, 32'h00000000, 3'd0};
    vecs[11] = '{1'b0, 32'h00700113, 6'd63, 32'h00000007, 3'd1};

    // Reset state.
    #2 chk_zero("reset");
    #10 reset_x = 1;
    @(posedge clk); #1;

    // Single request straight after reset.
    out_ready = 1;
    drive(0, 32'hFFF00093, 6'd5, 32'hFFFFFFFF, 3'd1);
    chk_rdy("single", 1, 0);
    step();
    idle();

    // Format table, back-to-back with out_ready high.
    foreach (vecs[i]) begin
      idle();
      drive(vecs[i].slot, vecs[i].inst, vecs[i].tag, vecs[i].imm, vecs[i].fmt);
      chk_rdy("table", !vecs[i].slot, vecs[i].slot);
      step();
      chk("table_imm", out_imm, vecs[i].imm);
    end
    idle();
    step();

    // Conflict: fresh prio, both slots held valid.
    reset_x = 0; #1 reset_x = 1; sbq.delete();
    drive(0, 32'h00500093, 6'h11, 32'd5, 3'd1);
    drive(1, 32'h00700113, 6'h22, 32'd7, 3'd1);
    for (int i = 0; i < 4; i++) begin
      es = RR ? i[0] : 1'b0;
      chk_rdy("conflict", !es, es);
      step();
      chk("conflict_src", {31'd0, out_src}, {31'd0, es});
    end

    // Backpressure with both slots still valid.
    out_ready = 0;
    s_imm = out_imm; s_tag = out_tag; s_src = out_src;
    for (int i = 0; i < 3; i++) begin
      chk_rdy("bp", 0, 0);
      step();
      chk("bp_hold_tag", {26'd0, out_tag}, {26'd0, s_tag});
      chk("bp_hold_src", {31'd0, out_src}, {31'd0, s_src});
    end
    out_ready = 1;
    chk_rdy("bp_release", 1, 0);
    step();
    chk("bp_release_src", {31'd0, out_src}, 32'd0);

    // Drain with nothing new: valid drops, payload holds.
    idle();
    s_imm = out_imm;
    step();
    chk("drain_hold_imm", out_imm, s_imm);

    // Flush blocks an in1 request for one cycle only.
    drive(0, 32'hFFF00093, 6'd13, 32'hFFFFFFFF, 3'd1);
    step();
    in0_valid = 0;
    drive(1, 32'h12345037, 6'd14, 32'h12345000, 3'd4);
    flush = 1;
    chk_rdy("flush", 0, 0);
    step();
    flush = 0;
    chk_rdy("post_flush", 0, 1);
    step();
    chk("post_flush_tag", {26'd0, out_tag}, 32'd14);
    idle();

    // Asynchronous reset while a stalled result is held.
    out_ready = 0;
    drive(0, 32'h00500093, 6'd15, 32'd5, 3'd1);
    step();
    in0_valid = 0;
    #2 reset_x = 0;
    #1 chk_zero("midreset");
    sbq.delete();
    @(posedge clk); #1;
    chk_zero("midreset_hold");
    reset_x = 1;
    out_ready = 1;
    drive(0, 32'h00500093, 6'd16, 32'd5, 3'd1);
    drive(1, 32'h00700113, 6'd17, 32'd7, 3'd1);
    chk_rdy("after_reset", 1, 0);
    step();
    chk("after_reset_src", {31'd0, out_src}, 32'd0);
    idle();
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
